bp_be_dcache_port_arbiter: RTL

- Shares the single D$ request port between up to num_req_p requesters: pipe_mem issue, PTW, and a future fence/debug sequencer.
- Uses round-robin arbitration with an optional multi-beat lock so a PTW walk keeps the port across its beats.
- Tracks which requester owns each in-flight access through the tag, early and final stages. The ptag, early_v and final_v signals are routed to that owner only.
- Sits between the requesters and bp_be_dcache, replacing an ad-hoc ptw_busy mux.

---
 rtl/bp_be_dcache_port_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bp_be_dcache_port_arbiter.sv
// Shares the single D$ request port among several requesters using round-robin grant with an optional multi-beat lock.
// Tracks which requester owns each in-flight access so that ptag, early and final handshakes reach only that owner.
module bp_be_dcache_port_arbiter
  #(parameter int num_req_p    = 3
  , parameter int pkt_width_p  = 72
  , parameter int ptag_width_p = 28
  , parameter int lock_max_p   = 15
  )
  (input  logic                              clk_i
  , input  logic                             reset_i
  , input  logic                             flush_i
  , input  logic [num_req_p-1:0]             req_v_i
  , input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i
  , input  logic [num_req_p-1:0]             req_lock_i
  , output logic [num_req_p-1:0]             req_yumi_o
  , input  logic [num_req_p*ptag_width_p-1:0] req_ptag_i
  , input  logic [num_req_p-1:0]             req_ptag_v_i
  , output logic                             dcache_v_o
  , output logic [pkt_width_p-1:0]           dcache_pkt_o
  , input  logic                             dcache_ready_i
  , output logic [ptag_width_p-1:0]          dcache_ptag_o
  , output logic                             dcache_ptag_v_o
  , input  logic                             dcache_early_v_i
  , input  logic                             dcache_final_v_i
  , output logic [num_req_p-1:0]             early_v_o
  , output logic [num_req_p-1:0]             final_v_o
  , output logic                             lock_timeout_o
  );

  localparam int owner_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int idle_w_lp  = $clog2(lock_max_p + 1);

  typedef logic [owner_w_lp-1:0] owner_t;
  typedef logic [idle_w_lp-1:0]  idle_t;

  // state      | meaning
  // e_unlocked | round-robin search from rr_q picks the next requester
  // e_locked   | only lock_owner_q may be granted; idle_q counts beats it skips
  typedef enum logic {e_unlocked, e_locked} state_e;

  state_e state_q, state_d;
  owner_t lock_owner_q, lock_owner_d;
  owner_t rr_q, rr_d;
  idle_t  idle_q, idle_d;
  logic   timeout_q, timeout_d;

  logic   s1_v_q, s2_v_q, s3_v_q;
  owner_t s1_owner_q, s2_owner_q, s3_owner_q;

  logic                 grant_v;
  owner_t               grant_idx;
  logic [num_req_p-1:0] grant_oh;
  logic [num_req_p-1:0] lock_sel;
  logic                 grant_lock;
  int                   scan_idx;

  always_comb begin
    lock_sel = '0;
    for (int i = 0; i < num_req_p; i++) begin
      lock_sel[i] = (lock_owner_q == owner_t'(i));
    end
  end

  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    if (!reset_i && dcache_ready_i && !flush_i) begin
      if (state_q == e_locked) begin
        grant_v   = |(req_v_i & lock_sel);
        grant_idx = lock_owner_q;
      end else begin
        for (int k = 0; k < num_req_p; k++) begin
          scan_idx = int'(rr_q) + k;
          if (scan_idx >= num_req_p) begin
            scan_idx = scan_idx - num_req_p;
          end
          for (int i = 0; i < num_req_p; i++) begin
            if (!grant_v && req_v_i[i] && (i == scan_idx)) begin
              grant_v   = 1'b1;
              grant_idx = owner_t'(i);
            end
          end
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < num_req_p; i++) begin
      grant_oh[i] = grant_v && (grant_idx == owner_t'(i));
    end
  end

  assign grant_lock = |(grant_oh & req_lock_i);
  assign req_yumi_o = grant_oh;
  assign dcache_v_o = grant_v;

  always_comb begin
    dcache_pkt_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant_oh[i]) begin
        dcache_pkt_o = req_pkt_i[i*pkt_width_p +: pkt_width_p];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    rr_d         = rr_q;
    idle_d       = idle_q;
    timeout_d    = 1'b0;
    case (state_q)
      e_unlocked: begin
        idle_d = '0;
        if (grant_v) begin
          rr_d = (grant_idx == owner_t'(num_req_p - 1)) ? '0 : grant_idx + owner_t'(1);
          if (grant_lock) begin
            state_d      = e_locked;
            lock_owner_d = grant_idx;
          end
        end
      end
      e_locked: begin
        if (flush_i) begin
          state_d = e_unlocked;
          idle_d  = '0;
        end else if (grant_v) begin
          idle_d = '0;
          if (!grant_lock) begin
            state_d = e_unlocked;
          end
        end else if (idle_q >= idle_t'(lock_max_p - 1)) begin
          // the increment that would reach lock_max_p force-releases instead
          state_d   = e_unlocked;
          idle_d    = '0;
          timeout_d = 1'b1;
        end else begin
          idle_d = idle_q + idle_t'(1);
        end
      end
      default: state_d = e_unlocked;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= e_unlocked;
      lock_owner_q <= '0;
      rr_q         <= '0;
      idle_q       <= '0;
      timeout_q    <= 1'b0;
      s1_v_q       <= 1'b0;
      s2_v_q       <= 1'b0;
      s3_v_q       <= 1'b0;
      s1_owner_q   <= '0;
      s2_owner_q   <= '0;
      s3_owner_q   <= '0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      rr_q         <= rr_d;
      idle_q       <= idle_d;
      timeout_q    <= timeout_d;
      s1_v_q       <= grant_v & ~flush_i;
      s2_v_q       <= s1_v_q & ~flush_i;
      s3_v_q       <= s2_v_q;
      s1_owner_q   <= grant_idx;
      s2_owner_q   <= s1_owner_q;
      s3_owner_q   <= s2_owner_q;
    end
  end

  assign lock_timeout_o = timeout_q;

  always_comb begin
    dcache_ptag_o   = '0;
    dcache_ptag_v_o = 1'b0;
    early_v_o       = '0;
    final_v_o       = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (s1_v_q && (s1_owner_q == owner_t'(i))) begin
        dcache_ptag_o   = req_ptag_i[i*ptag_width_p +: ptag_width_p];
        dcache_ptag_v_o = req_ptag_v_i[i];
      end
      early_v_o[i] = dcache_early_v_i & s2_v_q & (s2_owner_q == owner_t'(i));
      final_v_o[i] = dcache_final_v_i & s3_v_q & (s3_owner_q == owner_t'(i));
    end
  end

endmodule
